mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Two-master, one-slave arbiter on the cache-to-memory bus, directly downstream of the data cache's memory-side port (addr/data/we/rd/ack). Master 0 is the data cache and master 1 is the instruction cache. The arbiter multiplexes both onto the single memory port using round-robin priority. It holds each grant until the slave's ack, then inserts one release cycle so that a master's lingering strobe is not re-issued.

Parameters:
ADDR_WIDTH, 32, width of the address buses
DATA_WIDTH, 32, width of the data buses

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
m0_addr_i  input  ADDR_WIDTH  master 0 address
m0_data_i  input  DATA_WIDTH  master 0 write data
m0_data_o  output  DATA_WIDTH  master 0 read data
m0_we_i  input  1  master 0 write strobe
m0_rd_i  input  1  master 0 read strobe
m0_ack_o  output  1  master 0 completion pulse
m1_addr_i  input  ADDR_WIDTH  master 1 address
m1_data_i  input  DATA_WIDTH  master 1 write data
m1_data_o  output  DATA_WIDTH  master 1 read data
m1_we_i  input  1  master 1 write strobe
m1_rd_i  input  1  master 1 read strobe
m1_ack_o  output  1  master 1 completion pulse
addr_o  output  ADDR_WIDTH  slave address
data_o  output  DATA_WIDTH  slave write data
we_o  output  1  slave write strobe
rd_o  output  1  slave read strobe
data_i  input  DATA_WIDTH  slave read data, valid while ack_i=1
ack_i  input  1  slave completion pulse
grant_o  output  2  one-hot current grant; 00 when no master is granted

Behaviour:
- Single clock domain on clk. rst is synchronous and active-high.
- Reset (including mid-transfer):
  - state=IDLE, last_grant=1, grant_o=00.
  - we_o, rd_o, m0_ack_o, m1_ack_o are 0.
  - addr_o and data_o are 0.
  - An ack_i arriving in a reset cycle is dropped.
- Request definitions: req_k = mk_we_i | mk_rd_i.
- Strobe normalisation: if a master asserts we and rd together, we wins and rd_o is forced 0.
- State IDLE:
  - All slave strobes are 0 and grant_o=00.
  - If only one req_k is high, the next state is BUSY with grant=k.
  - If both are high, grant goes to the master != last_grant. After reset, master 0 therefore wins the first contest.
  - Grant is registered: strobes appear on the slave port 1 cycle after the request is first seen.
- State BUSY:
  - addr_o, data_o, we_o and rd_o are combinational muxes of the granted master's inputs. grant_o is one-hot for that master.
  - data_i is broadcast to m0_data_o and m1_data_o in every state.
  - ack_i is forwarded only to the granted master's mk_ack_o, combinationally in the same cycle. The other master's ack stays 0.
  - If ack_i=1: next state is RELEASE and last_grant is set to the granted master.
  - Abort: if the granted master drops both strobes with ack_i=0, next state is IDLE and last_grant is unchanged.
  - The other master's requests are ignored while BUSY.
- State RELEASE:
  - Lasts exactly 1 cycle. Slave strobes are 0, grant_o=00, and ack_i is not forwarded.
  - Next state is IDLE.
  - Minimum spacing between two slave transactions is therefore 2 idle cycles on the strobes.
- ack_i in IDLE or RELEASE: ignored, no mk_ack_o pulse.
- Outside BUSY: addr_o and data_o are 0.
- Transaction latency: request seen → strobe +1 cycle; ack_i → mk_ack_o 0 cycles.

Test Plan:
1. Reset, then m0_rd_i=1 with m0_addr_i=0x0000_0000; slave acks after 3 cycles with data_i=0x0000_0000 → rd_o rises 1 cycle after the request; grant_o=01; m0_ack_o pulses 1 cycle with m0_data_o=0; m1_ack_o stays 0; 1 RELEASE cycle with rd_o=0 even though m0_rd_i is still 1.
2. m0_we_i=1 (addr 0x4, data 0x0123_4567) and m1_rd_i=1 (addr 0x0001_0000) asserted on the same edge after reset → master 0 served first (we_o=1, data_o=0x0123_4567); after RELEASE and IDLE, master 1 is granted with rd_o=1 and addr_o=0x0001_0000.
3. Both masters request continuously, 4 transactions → grant_o sequence 01, 10, 01, 10; each ack goes only to its owner.
4. Master 1 granted, then drops m1_rd_i before any ack → rd_o falls the same cycle, state returns to IDLE; a subsequent contest still favours master 1 (last_grant unchanged).
5. Assert rst while BUSY with an ack_i pulse on the same edge → no mk_ack_o; all strobes are 0 and grant_o=00 on the next cycle; a following m0 request works normally.
6. ack_i pulsed in IDLE, and m0 asserts we and rd together → no ack forwarded from IDLE; for the dual-strobe request, we_o=1 and rd_o=0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-master, one-slave round-robin arbiter between the data cache (master 0),
// the instruction cache (master 1) and the single memory port. A grant is held
// until the slave acks, then one release cycle keeps a master's lingering strobe
// from being re-issued.
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  // master 0 (data cache)
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  input  logic [DATA_WIDTH-1:0] m0_data_i,
  output logic [DATA_WIDTH-1:0] m0_data_o,
  input  logic                  m0_we_i,
  input  logic                  m0_rd_i,
  output logic                  m0_ack_o,
  // master 1 (instruction cache)
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic [DATA_WIDTH-1:0] m1_data_i,
  output logic [DATA_WIDTH-1:0] m1_data_o,
  input  logic                  m1_we_i,
  input  logic                  m1_rd_i,
  output logic                  m1_ack_o,
  // slave (memory)
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  we_o,
  output logic                  rd_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  ack_i,
  output logic [1:0]            grant_o
);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StBusy    = 2'd1;
  localparam logic [1:0] StRelease = 2'd2;

  logic [1:0] state_q, state_d;
  // Index of the granted master while busy.
  logic       gnt_q, gnt_d;
  // Index of the master that last completed a transfer; loses the next tie.
  logic       last_q, last_d;

  logic                  req0, req1;
  logic                  sel_req;
  logic                  sel_we, sel_rd;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  busy;

  assign req0 = m0_we_i | m0_rd_i;
  assign req1 = m1_we_i | m1_rd_i;

  // Select the granted master's bus signals.
  always_comb begin
    if (gnt_q) begin
      sel_addr = m1_addr_i;
      sel_data = m1_data_i;
      sel_we   = m1_we_i;
      sel_rd   = m1_rd_i;
    end else begin
      sel_addr = m0_addr_i;
      sel_data = m0_data_i;
      sel_we   = m0_we_i;
      sel_rd   = m0_rd_i;
    end
  end

  assign sel_req = sel_we | sel_rd;

  // Next-state, grant and round-robin history.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    case (state_q)
      StIdle: begin
        if (req0 && req1) begin
          gnt_d   = ~last_q;
          state_d = StBusy;
        end else if (req0) begin
          gnt_d   = 1'b0;
          state_d = StBusy;
        end else if (req1) begin
          gnt_d   = 1'b1;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (ack_i) begin
          state_d = StRelease;
          last_d  = gnt_q;
        end else if (!sel_req) begin
          // Master aborted; history untouched so it keeps its priority.
          state_d = StIdle;
        end
      end
      StRelease: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
    end
  end

  // Reset masks the outputs in the same cycle so an ack racing a reset is dropped.
  assign busy = (state_q == StBusy) && !rst;

  // Slave-side and master-side outputs.
  always_comb begin
    addr_o    = busy ? sel_addr : '0;
    data_o    = busy ? sel_data : '0;
    we_o      = busy & sel_we;
    // Write wins when a master raises both strobes.
    rd_o      = busy & sel_rd & ~sel_we;
    m0_ack_o  = busy & ~gnt_q & ack_i;
    m1_ack_o  = busy & gnt_q & ack_i;
    grant_o   = busy ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
    m0_data_o = data_i;
    m1_data_o = data_i;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random
// traffic, all compared against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0;
  logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          m0_we = 1'b0, m0_rd = 1'b0, m1_we = 1'b0, m1_rd = 1'b0;
  logic          m0_ack, m1_ack;
  logic [AW-1:0] addr_o;
  logic [DW-1:0] data_o;
  logic          we_o, rd_o;
  logic [DW-1:0] data_i = '0;
  logic          ack_i = 1'b0;
  logic [1:0]    grant;

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the bus (-1 none), whether a cooldown cycle is
  // pending, and who finished last.
  int owner = -1;
  bit cool  = 1'b0;
  int last  = 1;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .m0_addr_i (m0_addr),
    .m0_data_i (m0_wdata),
    .m0_data_o (m0_rdata),
    .m0_we_i   (m0_we),
    .m0_rd_i   (m0_rd),
    .m0_ack_o  (m0_ack),
    .m1_addr_i (m1_addr),
    .m1_data_i (m1_wdata),
    .m1_data_o (m1_rdata),
    .m1_we_i   (m1_we),
    .m1_rd_i   (m1_rd),
    .m1_ack_o  (m1_ack),
    .addr_o    (addr_o),
    .data_o    (data_o),
    .we_o      (we_o),
    .rd_o      (rd_o),
    .data_i    (data_i),
    .ack_i     (ack_i),
    .grant_o   (grant)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare every output against what the model says for the current inputs.
  task automatic check_model();
    logic [1:0]    eg;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic          ewe, erd, ea0, ea1;
    eg = 2'b00; ea = '0; ed = '0; ewe = 0; erd = 0; ea0 = 0; ea1 = 0;
    if (!rst && owner == 0) begin
      eg = 2'b01; ea = m0_addr; ed = m0_wdata; ewe = m0_we; erd = m0_rd & ~m0_we; ea0 = ack_i;
    end else if (!rst && owner == 1) begin
      eg = 2'b10; ea = m1_addr; ed = m1_wdata; ewe = m1_we; erd = m1_rd & ~m1_we; ea1 = ack_i;
    end
    chk("grant", {62'b0, grant}, {62'b0, eg});
    chk("addr", {32'b0, addr_o}, {32'b0, ea});
    chk("wdata", {32'b0, data_o}, {32'b0, ed});
    chk("we", {63'b0, we_o}, {63'b0, ewe});
    chk("rd", {63'b0, rd_o}, {63'b0, erd});
    chk("ack0", {63'b0, m0_ack}, {63'b0, ea0});
    chk("ack1", {63'b0, m1_ack}, {63'b0, ea1});
    chk("rdata0", {32'b0, m0_rdata}, {32'b0, data_i});
    chk("rdata1", {32'b0, m1_rdata}, {32'b0, data_i});
  endtask

  task automatic update_model();
    bit r0, r1;
    r0 = m0_we | m0_rd;
    r1 = m1_we | m1_rd;
    if (rst) begin
      owner = -1; cool = 0; last = 1;
    end else if (owner >= 0) begin
      if (ack_i) begin
        last = owner; owner = -1; cool = 1;
      end else if (!(owner == 0 ? r0 : r1)) begin
        owner = -1;
      end
    end else if (cool) begin
      cool = 0;
    end else if (r0 && r1) begin
      owner = 1 - last;
    end else if (r0) begin
      owner = 0;
    end else if (r1) begin
      owner = 1;
    end
  endtask

  // One clock: check at the falling edge, advance the model, resume after the rising edge.
  task automatic step();
    @(negedge clk);
    check_model();
    update_model();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  logic [1:0] exp_seq [4];

  initial begin
    exp_seq[0] = 2'b01; exp_seq[1] = 2'b10; exp_seq[2] = 2'b01; exp_seq[3] = 2'b10;

    // 1: single read from master 0
    rst = 1; step(); step();
    rst = 0; step();
    chk("reset_grant", {62'b0, grant}, 64'd0);
    m0_rd = 1; m0_addr = 32'h0; settle();
    chk("t1_rd_registered", {63'b0, rd_o}, 64'd0);
    step();
    chk("t1_rd_up", {63'b0, rd_o}, 64'd1);
    chk("t1_grant", {62'b0, grant}, 64'd1);
    step(); step();
    ack_i = 1; data_i = 32'h0; settle();
    chk("t1_ack0", {63'b0, m0_ack}, 64'd1);
    chk("t1_ack1", {63'b0, m1_ack}, 64'd0);
    step();
    ack_i = 0; settle();
    chk("t1_release_rd", {63'b0, rd_o}, 64'd0);
    chk("t1_release_grant", {62'b0, grant}, 64'd0);
    m0_rd = 0; step();

    // 2: simultaneous write (m0) and read (m1) after reset
    rst = 1; step(); rst = 0;
    m0_we = 1; m0_addr = 32'h4; m0_wdata = 32'h0123_4567;
    m1_rd = 1; m1_addr = 32'h0001_0000;
    step();
    chk("t2_we", {63'b0, we_o}, 64'd1);
    chk("t2_wdata", {32'b0, data_o}, 64'h0123_4567);
    ack_i = 1; step();
    ack_i = 0; m0_we = 0; step();
    chk("t2_idle_grant", {62'b0, grant}, 64'd0);
    step();
    chk("t2_grant1", {62'b0, grant}, 64'd2);
    chk("t2_rd1", {63'b0, rd_o}, 64'd1);
    chk("t2_addr1", {32'b0, addr_o}, 64'h0001_0000);
    ack_i = 1; step();
    ack_i = 0; m1_rd = 0; step();

    // 3: both masters requesting continuously
    m0_rd = 1; m1_rd = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t3_grant", {62'b0, grant}, {62'b0, exp_seq[i]});
      ack_i = 1; data_i = $urandom; settle();
      chk("t3_ack0", {63'b0, m0_ack}, {63'b0, exp_seq[i][0]});
      chk("t3_ack1", {63'b0, m1_ack}, {63'b0, exp_seq[i][1]});
      step();
      ack_i = 0; step();
    end
    m0_rd = 0; m1_rd = 0;

    // 4: master 1 aborts; history stays with master 0's last completion
    m0_rd = 1; step(); ack_i = 1; step(); ack_i = 0; m0_rd = 0; step();
    m1_rd = 1; step();
    chk("t4_grant", {62'b0, grant}, 64'd2);
    m1_rd = 0; settle();
    chk("t4_abort_rd", {63'b0, rd_o}, 64'd0);
    step();
    m0_rd = 1; m1_rd = 1; step();
    chk("t4_contest", {62'b0, grant}, 64'd2);
    m0_rd = 0; m1_rd = 0; step();

    // 5: reset while busy with a racing ack
    m0_rd = 1; step();
    rst = 1; ack_i = 1; settle();
    chk("t5_ack_dropped", {63'b0, m0_ack}, 64'd0);
    step();
    rst = 0; ack_i = 0; settle();
    chk("t5_grant", {62'b0, grant}, 64'd0);
    chk("t5_rd", {63'b0, rd_o}, 64'd0);
    step();
    chk("t5_regrant", {62'b0, grant}, 64'd1);
    ack_i = 1; step(); ack_i = 0; m0_rd = 0; step();

    // 6: ack in idle, then dual-strobe request
    step();
    ack_i = 1; settle();
    chk("t6_idle_ack0", {63'b0, m0_ack}, 64'd0);
    chk("t6_idle_ack1", {63'b0, m1_ack}, 64'd0);
    step();
    ack_i = 0; m0_we = 1; m0_rd = 1; step();
    chk("t6_we", {63'b0, we_o}, 64'd1);
    chk("t6_rd", {63'b0, rd_o}, 64'd0);
    ack_i = 1; step(); ack_i = 0; m0_we = 0; m0_rd = 0; step();

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      rst      = ($urandom_range(0, 49) == 0);
      m0_we    = ($urandom_range(0, 3) == 0);
      m0_rd    = ($urandom_range(0, 2) == 0);
      m1_we    = ($urandom_range(0, 3) == 0);
      m1_rd    = ($urandom_range(0, 2) == 0);
      m0_addr  = $urandom; m1_addr  = $urandom;
      m0_wdata = $urandom; m1_wdata = $urandom;
      data_i   = $urandom;
      ack_i    = ($urandom_range(0, 2) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
